// File: rtl/img_pattern_gen_pkg.sv
// Shared constants and types for the sensor-side test-pattern transmitter.
package img_pattern_gen_pkg;

  localparam int unsigned Img_Width      = 2304;
  localparam int unsigned Img_Height     = 1296;
  localparam int unsigned Img_PixelWidth = 12;

  // Same start value and step that the pixel validator expects.
  localparam logic [Img_PixelWidth-1:0] Img_PixelInitial = 12'hFFF;
  localparam int                        Img_PixelDelta   = -1;

  typedef enum logic [2:0] {
    StIdle,
    StLead,
    StLine,
    StHBlank,
    StTrail,
    StDone
  } state_e;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/img_pattern_gen.sv
// Drives the parallel pixel bus with one deterministic ramp frame per cmd_frame toggle.
// All bus outputs change only while img_dclk falls, so they are stable at each dclk rise.
module img_pattern_gen
  import img_pattern_gen_pkg::*;
#(
  parameter int unsigned                  ImgWidth     = Img_Width,
  parameter int unsigned                  ImgHeight    = Img_Height,
  parameter int unsigned                  LineBlank    = 16,
  parameter int unsigned                  FvLead       = 8,
  parameter int unsigned                  FvTrail      = 8,
  parameter logic [Img_PixelWidth-1:0]    PixelInitial = Img_PixelInitial,
  parameter int                           PixelDelta   = Img_PixelDelta
) (
  input  logic                      clk,
  input  logic                      rst_,
  input  logic                      cmd_frame,
  output logic                      status_busy,
  output logic                      status_frameDone,
  output logic                      img_dclk,
  output logic [Img_PixelWidth-1:0] img_d,
  output logic                      img_fv,
  output logic                      img_lv
);

  localparam int unsigned PixW = Img_PixelWidth;
  localparam int unsigned ColW = $clog2(ImgWidth + 1);
  localparam int unsigned RowW = $clog2(ImgHeight + 1);
  localparam int unsigned CntW = $clog2(max3(LineBlank, FvLead, FvTrail) + 1);

  localparam logic [ColW-1:0] ColLast   = ColW'(ImgWidth - 1);
  localparam logic [RowW-1:0] RowLast   = RowW'(ImgHeight - 1);
  localparam logic [CntW-1:0] LeadLast  = CntW'(FvLead - 1);
  localparam logic [CntW-1:0] BlankLast = CntW'(LineBlank - 1);
  localparam logic [CntW-1:0] TrailLast = CntW'(FvTrail - 1);
  localparam logic [PixW-1:0] Delta     = PixW'(PixelDelta);

  state_e          r_state, w_state_nxt;
  logic            r_dclk;
  logic            r_armed;
  logic            r_cmd_prev;
  logic            r_pending, w_pending_nxt;
  logic [ColW-1:0] r_col, w_col_nxt;
  logic [RowW-1:0] r_row, w_row_nxt;
  logic [CntW-1:0] r_cnt, w_cnt_nxt;
  logic [PixW-1:0] r_pix, w_pix_nxt;
  logic [PixW-1:0] r_d, w_d_nxt;
  logic            r_fv, w_fv_nxt;
  logic            r_lv, w_lv_nxt;
  logic            r_busy, w_busy_nxt;
  logic            r_done, w_done_nxt;
  logic            w_toggle;
  logic            w_line_start;
  logic            w_emit;

  always_comb begin
    w_toggle      = r_armed && (cmd_frame != r_cmd_prev);
    w_state_nxt   = r_state;
    w_pending_nxt = r_pending | w_toggle;
    w_col_nxt     = r_col;
    w_row_nxt     = r_row;
    w_cnt_nxt     = r_cnt;
    w_pix_nxt     = r_pix;
    w_d_nxt       = r_d;
    w_fv_nxt      = r_fv;
    w_lv_nxt      = r_lv;
    w_busy_nxt    = r_busy;
    w_done_nxt    = r_done;
    w_line_start  = 1'b0;
    w_emit        = 1'b0;

    if (r_dclk) begin
      unique case (r_state)
        StIdle, StDone: begin
          if (r_pending) begin
            // A toggle landing on the accept edge merges into this request.
            w_pending_nxt = 1'b0;
            w_state_nxt   = StLead;
            w_fv_nxt      = 1'b1;
            w_busy_nxt    = 1'b1;
            w_cnt_nxt     = '0;
            w_row_nxt     = '0;
            w_pix_nxt     = PixelInitial;
          end else begin
            w_state_nxt = StIdle;
          end
        end
        StLead: begin
          if (r_cnt == LeadLast) w_line_start = 1'b1;
          else                   w_cnt_nxt    = r_cnt + 1'b1;
        end
        StLine: begin
          if (r_col == ColLast) begin
            w_lv_nxt  = 1'b0;
            w_d_nxt   = '0;
            w_cnt_nxt = '0;
            if (r_row == RowLast) begin
              w_state_nxt = StTrail;
            end else begin
              w_state_nxt = StHBlank;
              w_row_nxt   = r_row + 1'b1;
            end
          end else begin
            w_col_nxt = r_col + 1'b1;
            w_emit    = 1'b1;
          end
        end
        StHBlank: begin
          if (r_cnt == BlankLast) w_line_start = 1'b1;
          else                    w_cnt_nxt    = r_cnt + 1'b1;
        end
        StTrail: begin
          if (r_cnt == TrailLast) begin
            // The last trail period doubles as the done edge, so fv spans exactly one frame.
            w_state_nxt = StDone;
            w_fv_nxt    = 1'b0;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = ~r_done;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        default: w_state_nxt = StIdle;
      endcase

      if (w_line_start) begin
        w_state_nxt = StLine;
        w_lv_nxt    = 1'b1;
        w_col_nxt   = '0;
        w_emit      = 1'b1;
      end
      if (w_emit) begin
        w_d_nxt   = r_pix;
        w_pix_nxt = r_pix + Delta;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_state    <= StIdle;
      r_dclk     <= 1'b0;
      r_armed    <= 1'b0;
      r_cmd_prev <= 1'b0;
      r_pending  <= 1'b0;
      r_col      <= '0;
      r_row      <= '0;
      r_cnt      <= '0;
      r_pix      <= '0;
      r_d        <= '0;
      r_fv       <= 1'b0;
      r_lv       <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_dclk     <= ~r_dclk;
      r_armed    <= 1'b1;
      r_cmd_prev <= cmd_frame;
      r_pending  <= w_pending_nxt;
      r_col      <= w_col_nxt;
      r_row      <= w_row_nxt;
      r_cnt      <= w_cnt_nxt;
      r_pix      <= w_pix_nxt;
      r_d        <= w_d_nxt;
      r_fv       <= w_fv_nxt;
      r_lv       <= w_lv_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
    end
  end

  assign status_busy      = r_busy;
  assign status_frameDone = r_done;
  assign img_dclk         = r_dclk;
  assign img_d            = r_d;
  assign img_fv           = r_fv;
  assign img_lv           = r_lv;

endmodule

// File: tb/tb_img_pattern_gen.sv
// Bench for img_pattern_gen: small-frame instances checked against a frame model.
`timescale 1ns/1ps
module tb_img_pattern_gen;

  typedef struct packed {logic fv; logic lv; logic [11:0] d;} smp_t;
  typedef struct {int sel; int idx; logic [11:0] exp_d;} vec_t;

  logic clk  = 1'b0;
  logic rst_ = 1'b1;
  logic cmd_a = 1'b0, cmd_b = 1'b0, cmd_c = 1'b0;
  logic busy_a, done_a, dclk_a, fv_a, lv_a;
  logic busy_b, done_b, dclk_b, fv_b, lv_b;
  logic busy_c, done_c, dclk_c, fv_c, lv_c;
  logic [11:0] d_a, d_b, d_c;

  always #5 clk = ~clk;

  img_pattern_gen #(.ImgWidth(4), .ImgHeight(2), .LineBlank(2), .FvLead(1), .FvTrail(1),
                    .PixelInitial(12'hFFF), .PixelDelta(-1)) u_dut_a (
    .clk(clk), .rst_(rst_), .cmd_frame(cmd_a), .status_busy(busy_a),
    .status_frameDone(done_a), .img_dclk(dclk_a), .img_d(d_a), .img_fv(fv_a), .img_lv(lv_a));

  img_pattern_gen #(.ImgWidth(4), .ImgHeight(2), .LineBlank(2), .FvLead(1), .FvTrail(1),
                    .PixelInitial(12'hFFE), .PixelDelta(1)) u_dut_b (
    .clk(clk), .rst_(rst_), .cmd_frame(cmd_b), .status_busy(busy_b),
    .status_frameDone(done_b), .img_dclk(dclk_b), .img_d(d_b), .img_fv(fv_b), .img_lv(lv_b));

  img_pattern_gen #(.ImgWidth(5), .ImgHeight(3), .LineBlank(3), .FvLead(2), .FvTrail(3),
                    .PixelInitial(12'h005), .PixelDelta(-3)) u_dut_c (
    .clk(clk), .rst_(rst_), .cmd_frame(cmd_c), .status_busy(busy_c),
    .status_frameDone(done_c), .img_dclk(dclk_c), .img_d(d_c), .img_fv(fv_c), .img_lv(lv_c));

  int n_tests = 0;
  int n_fail  = 0;

  function automatic smp_t smp_of(input int s);
    case (s)
      0:       return {fv_a, lv_a, d_a};
      1:       return {fv_b, lv_b, d_b};
      default: return {fv_c, lv_c, d_c};
    endcase
  endfunction
  function automatic logic dclk_of(input int s);
    return (s == 0) ? dclk_a : (s == 1) ? dclk_b : dclk_c;
  endfunction
  function automatic logic done_of(input int s);
    return (s == 0) ? done_a : (s == 1) ? done_b : done_c;
  endfunction
  function automatic logic busy_of(input int s);
    return (s == 0) ? busy_a : (s == 1) ? busy_b : busy_c;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic toggle(input int s);
    case (s)
      0:       cmd_a = ~cmd_a;
      1:       cmd_b = ~cmd_b;
      default: cmd_c = ~cmd_c;
    endcase
  endtask

  // Stability at each dclk rise, plus fv-rise and done-toggle counters.
  int unstable = 0;
  int rise_a = 0, rise_c = 0, dtog_a = 0, dtog_c = 0;
  smp_t snap_a = '0, snap_c = '0;
  logic pfv_a = 1'b0, pfv_c = 1'b0, pdone_a = 1'b0, pdone_c = 1'b0;
  always @(negedge clk) begin
    if (!rst_) begin
      snap_a <= '0; snap_c <= '0;
      pfv_a <= 1'b0; pfv_c <= 1'b0; pdone_a <= 1'b0; pdone_c <= 1'b0;
    end else begin
      if ((dclk_a && ({fv_a, lv_a, d_a} !== snap_a)) ||
          (dclk_c && ({fv_c, lv_c, d_c} !== snap_c))) unstable <= unstable + 1;
      snap_a <= {fv_a, lv_a, d_a};
      snap_c <= {fv_c, lv_c, d_c};
      if (fv_a && !pfv_a) rise_a <= rise_a + 1;
      if (fv_c && !pfv_c) rise_c <= rise_c + 1;
      if (done_a != pdone_a) dtog_a <= dtog_a + 1;
      if (done_c != pdone_c) dtog_c <= dtog_c + 1;
      pfv_a <= fv_a; pfv_c <= fv_c; pdone_a <= done_a; pdone_c <= done_c;
    end
  end

  // Frame as a list of pixel periods while fv is high, built from the frame geometry.
  task automatic build_exp(input int w, input int h, input int lb, input int ld, input int tr,
                           input logic [11:0] init, input int delta, output smp_t q[$]);
    int k;
    k = 0;
    q.delete();
    repeat (ld) q.push_back({1'b1, 1'b0, 12'h000});
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        q.push_back({1'b1, 1'b1, 12'(int'(init) + k * delta)});
        k++;
      end
      if (r < h - 1) repeat (lb) q.push_back({1'b1, 1'b0, 12'h000});
    end
    repeat (tr) q.push_back({1'b1, 1'b0, 12'h000});
  endtask

  task automatic cmp_trace(input string name, input smp_t got[$], input smp_t exp[$]);
    int bad;
    bad = -1;
    n_tests++;
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      if (bad < 0 && got[i] !== exp[i]) bad = i;
    if (got.size() != exp.size() || bad >= 0) begin
      n_fail++;
      $display("FAIL %s: got %0d periods, expected %0d; first differing period %0d",
               name, got.size(), exp.size(), bad);
    end
  endtask

  task automatic capture(input int s, output smp_t q[$], output int lat, output int dtog,
                         output bit busy_seen, output bit timed_out);
    int n;
    bit started;
    logic d0;
    smp_t v;
    n = 0; started = 0; lat = -1; busy_seen = 0; timed_out = 1;
    q.delete();
    d0 = done_of(s);
    while (n < 400) begin
      @(negedge clk);
      n++;
      v = smp_of(s);
      if (!started && v.fv) begin
        started = 1; lat = n; busy_seen = busy_of(s);
      end
      if (started && dclk_of(s)) begin
        if (v.fv) q.push_back(v);
        else begin
          timed_out = 0;
          break;
        end
      end
    end
    dtog = (done_of(s) !== d0) ? 1 : 0;
  endtask

  task automatic observe(input int s, input int nper, output smp_t q[$]);
    q.delete();
    while (q.size() < nper) begin
      @(negedge clk);
      if (dclk_of(s)) q.push_back(smp_of(s));
    end
  endtask

  initial begin
    vec_t vecs[16];
    smp_t q[$], e[$], px_a[$], px_b[$];
    int lat, dt, r0, t0, n, i0, i1, i2, extra, exp_frames;
    bit bz, to, pend, mid;
    logic d0, plv;
    logic [11:0] pa [8] = '{12'hFFF, 12'hFFE, 12'hFFD, 12'hFFC,
                            12'hFFB, 12'hFFA, 12'hFF9, 12'hFF8};
    logic [11:0] pb [8] = '{12'hFFE, 12'hFFF, 12'h000, 12'h001,
                            12'h002, 12'h003, 12'h004, 12'h005};
    for (int i = 0; i < 8; i++) begin
      vecs[i]     = '{sel: 0, idx: i, exp_d: pa[i]};
      vecs[i + 8] = '{sel: 1, idx: i, exp_d: pb[i]};
    end

    #1 rst_ = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs_a", {busy_a, done_a, dclk_a, fv_a, lv_a, d_a}, 0);
    check("reset_outputs_b", {busy_b, done_b, dclk_b, fv_b, lv_b, d_b}, 0);
    check("reset_outputs_c", {busy_c, done_c, dclk_c, fv_c, lv_c, d_c}, 0);
    rst_ = 1'b1;
    repeat (10) @(negedge clk);
    check("no_spurious_frame", rise_a + rise_c, 0);

    // One frame each on A (down-count) and B (up-count with wrap).
    for (int s = 0; s < 2; s++) begin
      toggle(s);
      capture(s, q, lat, dt, bz, to);
      check("capture_timeout", to, 0);
      check("cmd_latency_in_1_to_3", (lat >= 1 && lat <= 3), 1);
      check("fv_high_periods", q.size(), 12);
      check("done_toggled_once", dt, 1);
      check("busy_during_frame", bz, 1);
      check("busy_after_frame", busy_of(s), 0);
      build_exp(4, 2, 2, 1, 1, (s == 0) ? 12'hFFF : 12'hFFE, (s == 0) ? -1 : 1, e);
      cmp_trace("frame_trace", q, e);
      foreach (q[i]) if (q[i].lv) begin
        if (s == 0) px_a.push_back(q[i].d); else px_b.push_back(q[i].d);
      end
      repeat (4) @(negedge clk);
    end
    for (int i = 0; i < 16; i++)
      check($sformatf("pixel_%0d_sel%0d", vecs[i].idx, vecs[i].sel),
            (vecs[i].sel == 0) ? px_a[vecs[i].idx] : px_b[vecs[i].idx], vecs[i].exp_d);

    // Three toggles spanning two clocks while idle collapse into one frame.
    r0 = rise_a; d0 = done_a;
    @(negedge clk);
    if (!dclk_a) @(negedge clk);
    toggle(0); @(negedge clk);
    toggle(0); @(negedge clk);
    toggle(0);
    capture(0, q, lat, dt, bz, to);
    repeat (40) @(negedge clk);
    check("collapse_one_frame", rise_a - r0, 1);
    check("collapse_done_toggle", done_a ^ d0, 1);

    // A toggle during Line queues exactly one more frame after a one-period fv gap.
    r0 = rise_a; t0 = dtog_a;
    toggle(0);
    n = 0;
    while (!lv_a && n < 50) begin @(negedge clk); n++; end
    check("lv_reached", lv_a, 1);
    toggle(0);
    observe(0, 60, q);
    i0 = -1; i1 = -1; i2 = -1; extra = 0;
    foreach (q[i]) begin
      if (i0 < 0 && !q[i].fv) i0 = i;
      else if (i0 >= 0 && i1 < 0 && q[i].fv) i1 = i;
      else if (i1 >= 0 && i2 < 0 && !q[i].fv) i2 = i;
      else if (i2 >= 0 && q[i].fv) extra++;
    end
    check("b2b_fv_gap", i1 - i0, 1);
    check("b2b_second_frame_len", i2 - i1, 12);
    check("b2b_no_third_frame", extra, 0);
    check("b2b_frame_count", rise_a - r0, 2);
    check("b2b_done_toggles", dtog_a - t0, 2);

    // Reset asserted during the second line.
    toggle(0);
    n = 0; plv = 1'b0; r0 = 0;
    while (r0 < 2 && n < 100) begin
      @(negedge clk);
      n++;
      if (lv_a && !plv) r0++;
      plv = lv_a;
    end
    check("second_line_reached", r0, 2);
    rst_ = 1'b0;
    #1;
    check("async_reset_outputs", {busy_a, done_a, dclk_a, fv_a, lv_a, d_a}, 0);
    @(negedge clk);
    rst_ = 1'b1;
    r0 = rise_a;
    repeat (60) @(negedge clk);
    check("post_reset_no_frame", rise_a - r0, 0);
    check("post_reset_done_low", done_a, 0);

    // Random idle gaps and random mid-frame toggles on C against the frame model.
    build_exp(5, 3, 3, 2, 3, 12'h005, -3, e);
    exp_frames = 0; pend = 0;
    r0 = rise_c; t0 = dtog_c;
    for (int it = 0; it < 8 || pend; it++) begin
      if (!pend) begin
        repeat ($urandom_range(0, 12)) @(negedge clk);
        toggle(2);
      end
      mid = 1'($urandom_range(0, 1));
      fork
        capture(2, q, lat, dt, bz, to);
        if (mid) begin
          repeat ($urandom_range(5, 40)) @(negedge clk);
          toggle(2);
        end
      join
      exp_frames++;
      pend = mid;
      check("rand_capture_timeout", to, 0);
      cmp_trace("rand_frame_trace", q, e);
    end
    repeat (20) @(negedge clk);
    check("rand_frame_count", rise_c - r0, exp_frames);
    check("rand_done_toggles", dtog_c - t0, exp_frames);
    check("sample_point_stable", unstable, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
